// File: rtl/weight_mem_loader_pkg.sv
// weight_mem_loader_pkg
//   Shared definitions for the layer weight loader:
//   - wml_state_e : loader FSM state encoding
//   - clog2_min1  : ceil(log2(n)) clamped to at least 1, used for the neuron-index width
package weight_mem_loader_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StDone = 2'd2
    } wml_state_e;

    // A single-neuron layer still needs a 1-bit index register.
    function automatic int unsigned clog2_min1(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) begin
            result = result + 1;
        end
        if (result == 0) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/weight_addr_counter.sv
// weight_addr_counter
//   Nested weight/neuron counter for the weight loader. wcnt walks 0..numWeight-1 for the
//   current neuron; when it wraps, ncnt moves to the next neuron. ncnt wraps to 0 after the
//   last neuron so the counter is left in a clean state after a full load.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   clear     : zero both counters (start of a new load)
//   advance   : one weight word has been accepted
//   wcnt      : weight address within the current neuron (addressWidth+1 bits)
//   ncnt      : current neuron index
//   w_last    : wcnt is at numWeight-1
//   n_last    : ncnt is at numNeurons-1
module weight_addr_counter
    import weight_mem_loader_pkg::*;
#(
    parameter int unsigned numNeurons   = 30,
    parameter int unsigned numWeight    = 784,
    parameter int unsigned addressWidth = 10
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   clear,
    input  logic                                   advance,
    output logic [addressWidth:0]                  wcnt,
    output logic [clog2_min1(numNeurons)-1:0]      ncnt,
    output logic                                   w_last,
    output logic                                   n_last
);

    localparam int unsigned NcntW = clog2_min1(numNeurons);
    localparam int unsigned WcntW = addressWidth + 1;

    localparam logic [WcntW-1:0] WcntMax = WcntW'(numWeight - 1);
    localparam logic [NcntW-1:0] NcntMax = NcntW'(numNeurons - 1);

    logic [WcntW-1:0] wcnt_q, wcnt_d;
    logic [NcntW-1:0] ncnt_q, ncnt_d;

    assign w_last = (wcnt_q == WcntMax);
    assign n_last = (ncnt_q == NcntMax);
    assign wcnt   = wcnt_q;
    assign ncnt   = ncnt_q;

    always_comb begin
        wcnt_d = wcnt_q;
        ncnt_d = ncnt_q;
        if (clear) begin
            wcnt_d = '0;
            ncnt_d = '0;
        end else if (advance) begin
            if (w_last) begin
                wcnt_d = '0;
                ncnt_d = n_last ? '0 : ncnt_q + NcntW'(1);
            end else begin
                wcnt_d = wcnt_q + WcntW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt_q <= '0;
            ncnt_q <= '0;
        end else begin
            wcnt_q <= wcnt_d;
            ncnt_q <= ncnt_d;
        end
    end

endmodule

// File: rtl/weight_mem_loader.sv
// weight_mem_loader
//   Write-side loader for one layer's per-neuron weight memories. A start pulse begins a load;
//   weight words arrive on a valid/ready stream and are written neuron by neuron, numWeight
//   words per neuron, one registered write per accepted word (1-cycle latency).
//   Optional framing check: define WLOAD_CHECK_EN to compare s_last against the final word
//   position and raise a sticky err; without it s_last is ignored and err is 0.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start             : begins a load when idle; ignored otherwise
//   s_valid/s_ready   : stream handshake; s_ready is high while loading
//   s_data, s_last    : stream word and end-of-layer marker
//   wen               : one-hot write enable, bit n targets neuron n
//   waddr, wdata      : write address and data shared by all memories
//   busy              : high while loading
//   done              : one-cycle pulse alongside the final write
//   err               : sticky framing error
module weight_mem_loader
    import weight_mem_loader_pkg::*;
#(
    parameter int unsigned numNeurons   = 30,
    parameter int unsigned numWeight    = 784,
    parameter int unsigned addressWidth = 10,
    parameter int unsigned dataWidth    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    s_valid,
    input  logic [dataWidth-1:0]    s_data,
    input  logic                    s_last,
    output logic                    s_ready,
    output logic [numNeurons-1:0]   wen,
    output logic [addressWidth:0]   waddr,
    output logic [dataWidth-1:0]    wdata,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam int unsigned NcntW = clog2_min1(numNeurons);
    localparam logic [numNeurons-1:0] WenOne = numNeurons'(1);

    wml_state_e               state_q, state_d;
    logic [numNeurons-1:0]    wen_q, wen_d;
    logic [addressWidth:0]    waddr_q, waddr_d;
    logic [dataWidth-1:0]     wdata_q, wdata_d;
    logic                     done_q, done_d;

    logic                     accept;
    logic                     clear;
    logic                     final_word;
    logic [addressWidth:0]    wcnt;
    logic [NcntW-1:0]         ncnt;
    logic                     w_last;
    logic                     n_last;

    assign s_ready    = (state_q == StLoad);
    assign busy       = (state_q == StLoad);
    assign accept     = s_valid && s_ready;
    assign clear      = (state_q == StIdle) && start;
    assign final_word = accept && w_last && n_last;

    weight_addr_counter #(
        .numNeurons   (numNeurons),
        .numWeight    (numWeight),
        .addressWidth (addressWidth)
    ) u_addr_counter (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .advance (accept),
        .wcnt    (wcnt),
        .ncnt    (ncnt),
        .w_last  (w_last),
        .n_last  (n_last)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (start) state_d = StLoad;
            StLoad: if (final_word) state_d = StDone;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Address/data hold between writes; only wen marks a valid write.
        wen_d   = accept ? (WenOne << ncnt) : '0;
        waddr_d = accept ? wcnt : waddr_q;
        wdata_d = accept ? s_data : wdata_q;
        done_d  = final_word;
    end

`ifdef WLOAD_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (clear) begin
            err_d = 1'b0;
        end else if (accept && (s_last != (w_last && n_last))) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    logic unused_s_last;
    assign unused_s_last = s_last;
    assign err           = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            wen_q   <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
        end
    end

    assign wen   = wen_q;
    assign waddr = waddr_q;
    assign wdata = wdata_q;
    assign done  = done_q;

endmodule

// File: tb/tb_weight_mem_loader.sv
module tb_weight_mem_loader;

    localparam int unsigned NN = 4;
    localparam int unsigned NW = 3;
    localparam int unsigned AW = 2;
    localparam int unsigned DW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic            start;
    logic            s_valid;
    logic [DW-1:0]   s_data;
    logic            s_last;

    logic            s_ready;
    logic [NN-1:0]   wen;
    logic [AW:0]     waddr;
    logic [DW-1:0]   wdata;
    logic            busy;
    logic            done;
    logic            err;

    logic            s_ready1;
    logic [0:0]      wen1;
    logic [AW:0]     waddr1;
    logic [DW-1:0]   wdata1;
    logic            busy1;
    logic            done1;
    logic            err1;

    int nvec  = 0;
    int nfail = 0;

    // Expected one-hot enable for each of the 12 writes of a 4x3 layer.
    logic [NN-1:0] exp_wen [12] = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010,
                                    4'b0100, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b1000};
    logic [AW:0]   exp_addr [12] = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2,
                                     3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2};

    weight_mem_loader #(
        .numNeurons   (NN),
        .numWeight    (NW),
        .addressWidth (AW),
        .dataWidth    (DW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .s_valid (s_valid),
        .s_data  (s_data),
        .s_last  (s_last),
        .s_ready (s_ready),
        .wen     (wen),
        .waddr   (waddr),
        .wdata   (wdata),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    weight_mem_loader #(
        .numNeurons   (1),
        .numWeight    (4),
        .addressWidth (AW),
        .dataWidth    (DW)
    ) dut1 (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .s_valid (s_valid),
        .s_data  (s_data),
        .s_last  (s_last),
        .s_ready (s_ready1),
        .wen     (wen1),
        .waddr   (waddr1),
        .wdata   (wdata1),
        .busy    (busy1),
        .done    (done1),
        .err     (err1)
    );

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        nvec++; if (s_ready !== 1'b0) begin nfail++; $display("FAIL reset_s_ready got %0h want 0", s_ready); end
        nvec++; if (wen !== 4'b0000) begin nfail++; $display("FAIL reset_wen got %0h want 0", wen); end
        nvec++; if (waddr !== 3'd0) begin nfail++; $display("FAIL reset_waddr got %0h want 0", waddr); end
        nvec++; if (wdata !== 16'h0000) begin nfail++; $display("FAIL reset_wdata got %0h want 0", wdata); end
        nvec++; if (busy !== 1'b0) begin nfail++; $display("FAIL reset_busy got %0h want 0", busy); end
        nvec++; if (done !== 1'b0) begin nfail++; $display("FAIL reset_done got %0h want 0", done); end
        nvec++; if (err !== 1'b0) begin nfail++; $display("FAIL reset_err got %0h want 0", err); end
        nvec++; if (busy1 !== 1'b0) begin nfail++; $display("FAIL reset_busy1 got %0h want 0", busy1); end
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        nvec++; if (busy !== 1'b1) begin nfail++; $display("FAIL b2b_busy_start got %0h want 1", busy); end
        nvec++; if (err !== 1'b0) begin nfail++; $display("FAIL b2b_err_start got %0h want 0", err); end
        for (int i = 0; i < 12; i++) begin
            s_valid = 1'b1; s_data = DW'(i + 1); s_last = (i == 11);
            nvec++; if (s_ready !== 1'b1) begin nfail++; $display("FAIL b2b_s_ready[%0d] got %0h want 1", i, s_ready); end
            @(posedge clk); #1;
            nvec++; if (wen !== exp_wen[i]) begin nfail++; $display("FAIL b2b_wen[%0d] got %b want %b", i, wen, exp_wen[i]); end
            nvec++; if (waddr !== exp_addr[i]) begin nfail++; $display("FAIL b2b_waddr[%0d] got %0d want %0d", i, waddr, exp_addr[i]); end
            nvec++; if (wdata !== DW'(i + 1)) begin nfail++; $display("FAIL b2b_wdata[%0d] got %0h want %0h", i, wdata, i + 1); end
            nvec++; if (done !== (i == 11)) begin nfail++; $display("FAIL b2b_done[%0d] got %0h want %0h", i, done, (i == 11)); end
            nvec++; if (busy !== (i != 11)) begin nfail++; $display("FAIL b2b_busy[%0d] got %0h want %0h", i, busy, (i != 11)); end
            nvec++; if (err !== 1'b0) begin nfail++; $display("FAIL b2b_err[%0d] got %0h want 0", i, err); end
        end
        s_valid = 1'b0; s_last = 1'b0;
        @(posedge clk); #1;
        nvec++; if (wen !== 4'b0000) begin nfail++; $display("FAIL b2b_wen_after got %b want 0000", wen); end
        nvec++; if (done !== 1'b0) begin nfail++; $display("FAIL b2b_done_after got %0h want 0", done); end
        nvec++; if (s_ready !== 1'b0) begin nfail++; $display("FAIL b2b_s_ready_after got %0h want 0", s_ready); end
    endtask

    task automatic test_gaps();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            s_valid = 1'b0; s_data = 16'hDEAD; s_last = 1'b0;
            @(posedge clk); #1;
            nvec++; if (wen !== 4'b0000) begin nfail++; $display("FAIL gap_wen[%0d] got %b want 0000", i, wen); end
            nvec++; if (busy !== 1'b1) begin nfail++; $display("FAIL gap_busy[%0d] got %0h want 1", i, busy); end
            nvec++; if (done !== 1'b0) begin nfail++; $display("FAIL gap_done[%0d] got %0h want 0", i, done); end
            s_valid = 1'b1; s_data = DW'(i + 1); s_last = (i == 11);
            @(posedge clk); #1;
            nvec++; if (wen !== exp_wen[i]) begin nfail++; $display("FAIL gapw_wen[%0d] got %b want %b", i, wen, exp_wen[i]); end
            nvec++; if (waddr !== exp_addr[i]) begin nfail++; $display("FAIL gapw_waddr[%0d] got %0d want %0d", i, waddr, exp_addr[i]); end
            nvec++; if (wdata !== DW'(i + 1)) begin nfail++; $display("FAIL gapw_wdata[%0d] got %0h want %0h", i, wdata, i + 1); end
            nvec++; if (done !== (i == 11)) begin nfail++; $display("FAIL gapw_done[%0d] got %0h want %0h", i, done, (i == 11)); end
        end
        s_valid = 1'b0; s_last = 1'b0;
        @(posedge clk); #1;
        nvec++; if (busy !== 1'b0) begin nfail++; $display("FAIL gap_busy_end got %0h want 0", busy); end
    endtask

    task automatic test_midload_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i == 5) begin
                start = 1'b1; s_valid = 1'b0;
                @(posedge clk); #1;
                start = 1'b0;
                nvec++; if (wen !== 4'b0000) begin nfail++; $display("FAIL mid_start_wen got %b want 0000", wen); end
                nvec++; if (busy !== 1'b1) begin nfail++; $display("FAIL mid_start_busy got %0h want 1", busy); end
            end
            s_valid = 1'b1; s_data = DW'(16'h0100 + i); s_last = (i == 11);
            @(posedge clk); #1;
            nvec++; if (wen !== exp_wen[i]) begin nfail++; $display("FAIL mid_wen[%0d] got %b want %b", i, wen, exp_wen[i]); end
            nvec++; if (waddr !== exp_addr[i]) begin nfail++; $display("FAIL mid_waddr[%0d] got %0d want %0d", i, waddr, exp_addr[i]); end
            nvec++; if (wdata !== DW'(16'h0100 + i)) begin nfail++; $display("FAIL mid_wdata[%0d] got %0h want %0h", i, wdata, 16'h0100 + i); end
            nvec++; if (done !== (i == 11)) begin nfail++; $display("FAIL mid_done[%0d] got %0h want %0h", i, done, (i == 11)); end
        end
        s_valid = 1'b0; s_last = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midload();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            s_valid = 1'b1; s_data = DW'(i + 1); s_last = 1'b0;
            @(posedge clk); #1;
            nvec++; if (wen !== exp_wen[i]) begin nfail++; $display("FAIL rstm_wen[%0d] got %b want %b", i, wen, exp_wen[i]); end
        end
        // Word 8 presented in the reset cycle must not be written.
        rst = 1'b1; s_valid = 1'b1; s_data = 16'h0008;
        @(posedge clk); #1;
        nvec++; if (wen !== 4'b0000) begin nfail++; $display("FAIL rstm_wen got %b want 0000", wen); end
        nvec++; if (waddr !== 3'd0) begin nfail++; $display("FAIL rstm_waddr got %0d want 0", waddr); end
        nvec++; if (wdata !== 16'h0000) begin nfail++; $display("FAIL rstm_wdata got %0h want 0", wdata); end
        nvec++; if (busy !== 1'b0) begin nfail++; $display("FAIL rstm_busy got %0h want 0", busy); end
        nvec++; if (s_ready !== 1'b0) begin nfail++; $display("FAIL rstm_s_ready got %0h want 0", s_ready); end
        nvec++; if (done !== 1'b0) begin nfail++; $display("FAIL rstm_done got %0h want 0", done); end
        rst = 1'b0; s_valid = 1'b0;
        @(posedge clk); #1;
        nvec++; if (busy !== 1'b0) begin nfail++; $display("FAIL rstm_idle_busy got %0h want 0", busy); end
    endtask

`ifdef WLOAD_CHECK_EN
    task automatic test_err();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            s_valid = 1'b1; s_data = DW'(i + 1); s_last = (i == 10);
            @(posedge clk); #1;
            nvec++; if (err !== (i >= 10)) begin nfail++; $display("FAIL err_err[%0d] got %0h want %0h", i, err, (i >= 10)); end
            nvec++; if (done !== (i == 11)) begin nfail++; $display("FAIL err_done[%0d] got %0h want %0h", i, done, (i == 11)); end
        end
        s_valid = 1'b0; s_last = 1'b0;
        @(posedge clk); #1;
        nvec++; if (err !== 1'b1) begin nfail++; $display("FAIL err_sticky got %0h want 1", err); end
    endtask
`endif

    task automatic test_single_neuron();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1; s_data = DW'(16'h00A1 + i); s_last = (i == 3);
            nvec++; if (s_ready1 !== 1'b1) begin nfail++; $display("FAIL one_s_ready[%0d] got %0h want 1", i, s_ready1); end
            @(posedge clk); #1;
            nvec++; if (wen1 !== 1'b1) begin nfail++; $display("FAIL one_wen[%0d] got %0h want 1", i, wen1); end
            nvec++; if (waddr1 !== (AW+1)'(i)) begin nfail++; $display("FAIL one_waddr[%0d] got %0d want %0d", i, waddr1, i); end
            nvec++; if (wdata1 !== DW'(16'h00A1 + i)) begin nfail++; $display("FAIL one_wdata[%0d] got %0h want %0h", i, wdata1, 16'h00A1 + i); end
            nvec++; if (done1 !== (i == 3)) begin nfail++; $display("FAIL one_done[%0d] got %0h want %0h", i, done1, (i == 3)); end
            nvec++; if (busy1 !== (i != 3)) begin nfail++; $display("FAIL one_busy[%0d] got %0h want %0h", i, busy1, (i != 3)); end
            nvec++; if (err1 !== 1'b0) begin nfail++; $display("FAIL one_err[%0d] got %0h want 0", i, err1); end
        end
        s_valid = 1'b0; s_last = 1'b0;
        @(posedge clk); #1;
        nvec++; if (wen1 !== 1'b0) begin nfail++; $display("FAIL one_wen_after got %0h want 0", wen1); end
        nvec++; if (done1 !== 1'b0) begin nfail++; $display("FAIL one_done_after got %0h want 0", done1); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_gaps();
        test_midload_start();
        test_reset_midload();
        test_back_to_back();
`ifdef WLOAD_CHECK_EN
        test_err();
        test_back_to_back();
`endif
        test_single_neuron();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/weight_mem_loader.md
Name: weight_mem_loader

Overview:
- Write-side counterpart of the per-neuron weight memories.
- Accepts a serial stream of weight words through a valid/ready handshake and distributes them neuron by neuron.
- Drives a one-hot write-enable, a write address and write data to the numNeurons weight memories of one layer.
- Sits between the AXI-side configuration path and the layer's weight RAMs; runs once per layer load, triggered by start.

Parameters:
- numNeurons, 30, number of neurons (weight memories) in the target layer; must be >= 1
- numWeight, 784, weights per neuron; must be >= 1 and <= 2**addressWidth
- addressWidth, 10, weight memory depth exponent; the address port is addressWidth+1 bits wide
- dataWidth, 16, weight word width

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse; begins a layer load when idle
- s_valid  in  1  stream word valid
- s_data  in  dataWidth  stream weight word
- s_last  in  1  marks the final word of the layer stream (used only with WLOAD_CHECK_EN)
- s_ready  out  1  loader accepts a word this cycle
- wen  out  numNeurons  one-hot write enable; bit n targets neuron n's memory
- waddr  out  addressWidth+1  write address, shared by all memories
- wdata  out  dataWidth  write data, shared by all memories
- busy  out  1  high while in LOAD
- done  out  1  one-cycle pulse when the last weight has been written
- err  out  1  sticky framing error (WLOAD_CHECK_EN only)

Behaviour:
- Reset values: s_ready=0, wen=0, waddr=0, wdata=0, busy=0, done=0, err=0; FSM=IDLE; wcnt=0; ncnt=0.
- Counters:
  - wcnt is addressWidth+1 bits.
  - ncnt is $clog2(numNeurons) bits, minimum 1.
- FSM states:
  - IDLE:
    - s_ready=0.
    - start=1 -> LOAD; clear wcnt, ncnt and err.
  - LOAD:
    - busy=1 and s_ready=1 (combinational from state).
    - A word is accepted on s_valid && s_ready.
    - On accept, the next cycle presents wen=(1<<ncnt), waddr=wcnt, wdata=s_data. Latency is exactly 1 cycle from accept to write, registered.
    - Then wcnt++.
    - If wcnt==numWeight-1: wcnt wraps to 0 and ncnt++.
    - If additionally ncnt==numNeurons-1 -> DONE.
  - DONE:
    - s_ready=0.
    - The final write is visible on wen this cycle; done=1 for exactly this cycle.
    - -> IDLE next cycle.
- wen is 0 in every cycle that does not follow an accept, including s_valid gaps; gaps cause no address advance.
- start while in LOAD or DONE is ignored.
- Back-to-back accepts sustain one write per cycle, with addresses 0..numWeight-1 contiguous per neuron.
- Reset mid-load:
  - All outputs and counters return to reset values on the next edge.
  - Any write registered in that cycle is dropped (wen=0).
  - A partial load is not resumed.
- numNeurons=1: ncnt stays 0; the transition to DONE occurs at wcnt==numWeight-1.

Optional Feature:
- Macro: WLOAD_CHECK_EN
- With the macro:
  - err is set when an accepted word has s_last=1 but is not the final word, or when the final word has s_last=0.
  - err is sticky until the next start or rst.
  - The load still completes by count, and done still pulses.
- Without the macro: s_last is ignored and err is tied to 0.

Decomposition:
- Shared package:
  - FSM state encoding (IDLE=2'd0, LOAD=2'd1, DONE=2'd2).
  - Clog2 helper constant function for the neuron-index width.
- One natural sub-module: weight_addr_counter, the nested wcnt/ncnt counter with wrap and last-flag outputs.
- The FSM and write register stage stay in the top.

Test Plan (numNeurons=4, numWeight=3, addressWidth=2, dataWidth=16 unless noted):
- Reset then start, 12 back-to-back words 0x0001..0x000C:
  - wen sequence 0001x3, 0010x3, 0100x3, 1000x3.
  - waddr 0,1,2 repeating; wdata matches input with 1-cycle lag.
  - done pulses once, aligned with the 0x000C write.
- Same stream with s_valid low on every other cycle -> identical write sequence, with wen=0 in the gap cycles; busy held high throughout.
- start pulsed again mid-load after word 5 -> ignored; the sequence continues at neuron 1, address 2.
- rst asserted after word 7 -> next cycle all outputs are 0 and the FSM is IDLE; a new start plus 12 words reloads from neuron 0, address 0.
- WLOAD_CHECK_EN defined:
  - s_last asserted on word 11 -> err=1 from the cycle after word 11 while done still pulses after word 12.
  - Correct s_last on word 12 -> err stays 0.
- numNeurons=1, numWeight=4 -> wen=1 for addresses 0..3; done on the 4th write.
